fifo_tx_scheduler: RTL and testbench

FIFO_TX_SCHEDULER -- requirements
Module: fifo_tx_scheduler

---
 rtl/fifo_tx_scheduler.sv | 112 +++++++++++
 tb/tb_fifo_tx_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_scheduler.sv
// rtl/fifo_tx_scheduler.sv - CPU-to-FIFO write path and FIFO-to-UART byte scheduler with optional inter-byte gap.
module fifo_tx_scheduler #(
   parameter int GAP_CYCLES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        cpu_write,
   input  logic [7:0]  cpu_data,
   input  logic        flush,
   input  logic        clear_overflow,
   input  logic        fifo_full,
   input  logic        fifo_empty,
   input  logic [7:0]  fifo_rdata,
   input  logic        tx_busy,
   output logic        fifo_write,
   output logic [7:0]  fifo_wdata,
   output logic        fifo_read,
   output logic        fifo_clear,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   output logic        cpu_ready,
   output logic        overflow,
   output logic [15:0] sent_count
);

   typedef enum logic [2:0] {
      IDLE,
      POP,
      LOAD,
      WAIT_ACK,
      WAIT_DONE,
      GAP
   } state_t;

   localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

   state_t     state;
   state_t     state_next;
   logic [7:0] gap_cnt;
   logic [7:0] gap_next;

   assign fifo_write = cpu_write & ~fifo_full & ~fifo_clear;
   assign fifo_wdata = cpu_data;
   assign cpu_ready  = ~fifo_full;

   always_comb begin
      state_next = state;
      gap_next   = gap_cnt;
      fifo_read  = 1'b0;
      fifo_clear = 1'b0;
      tx_start   = 1'b0;
      case (state)
         IDLE: begin
            if (flush) begin
               fifo_clear = 1'b1;
            end else if (enable && !fifo_empty) begin
               fifo_read  = 1'b1;
               state_next = POP;
            end
         end
         POP: state_next = LOAD;
         LOAD: begin
            tx_start   = 1'b1;
            state_next = WAIT_ACK;
         end
         WAIT_ACK: begin
            if (tx_busy) state_next = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               if (GAP_CYCLES == 0) begin
                  state_next = IDLE;
               end else begin
                  gap_next   = GAP_LOAD;
                  state_next = GAP;
               end
            end
         end
         GAP: begin
            if (gap_cnt == 8'd0) state_next = IDLE;
            else                 gap_next   = gap_cnt - 8'd1;
         end
         default: state_next = IDLE;
      endcase
      // Pulses stay low while reset is held, so a byte popped before reset is never started.
      if (reset) begin
         fifo_read  = 1'b0;
         fifo_clear = 1'b0;
         tx_start   = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         gap_cnt    <= 8'd0;
         tx_data    <= 8'h00;
         overflow   <= 1'b0;
         sent_count <= 16'h0000;
      end else begin
         state   <= state_next;
         gap_cnt <= gap_next;
         // Non-showahead read data is valid during POP, so tx_data is ready for the start pulse.
         if (state == POP) tx_data <= fifo_rdata;
         if (state == LOAD) sent_count <= sent_count + 16'd1;
         if (cpu_write && fifo_full) overflow <= 1'b1;
         else if (clear_overflow)    overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// tb/tb_fifo_tx_scheduler.sv - bench for fifo_tx_scheduler with emulated FIFO and transmitter.
module tb_fifo_tx_scheduler;

   localparam int GAP   = 3;
   localparam int DEPTH = 4;

   logic        clock = 1'b0;
   logic        reset, enable, cpu_write, flush, clear_overflow;
   logic [7:0]  cpu_data;
   logic        fifo_full, fifo_empty, tx_busy = 1'b0;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        fifo_write, fifo_read, fifo_clear, tx_start, cpu_ready, overflow;
   logic [7:0]  fifo_wdata, tx_data;
   logic [15:0] sent_count;

   fifo_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
      .clock(clock), .reset(reset), .enable(enable), .cpu_write(cpu_write),
      .cpu_data(cpu_data), .flush(flush), .clear_overflow(clear_overflow),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_rdata(fifo_rdata),
      .tx_busy(tx_busy), .fifo_write(fifo_write), .fifo_wdata(fifo_wdata),
      .fifo_read(fifo_read), .fifo_clear(fifo_clear), .tx_start(tx_start),
      .tx_data(tx_data), .cpu_ready(cpu_ready), .overflow(overflow),
      .sent_count(sent_count)
   );

   always #5 clock = ~clock;

   logic [7:0]  q[$];
   int          q_count = 0;
   logic        force_full = 1'b0;
   int unsigned cyc = 0;
   logic        cap_read = 1'b0, cap_write = 1'b0, cap_clear = 1'b0, cap_start = 1'b0;
   logic [7:0]  cap_wdata = 8'h00;
   int          ack_delay = 1, busy_len = 10, ack_cnt = 0, busy_cnt = 0;
   int          vectors = 0, miscompares = 0;

   assign fifo_full  = (q_count >= DEPTH) | force_full;
   assign fifo_empty = (q_count == 0);

   always @(negedge clock) begin
      cap_read  = fifo_read;
      cap_write = fifo_write;
      cap_clear = fifo_clear;
      cap_start = tx_start;
      cap_wdata = fifo_wdata;
   end

   // Environment: a DEPTH-entry non-showahead FIFO and a UART that acks after ack_delay cycles.
   always @(posedge clock) begin
      cyc++;
      #1;
      if (cap_clear) q.delete();
      else begin
         if (cap_read && q.size() > 0) fifo_rdata = q.pop_front();
         if (cap_write && q.size() < DEPTH) q.push_back(cap_wdata);
      end
      q_count = q.size();
      if (cap_start) begin
         ack_cnt  = ack_delay;
         busy_cnt = busy_len;
      end
      if (tx_busy) begin
         busy_cnt--;
         if (busy_cnt <= 0) tx_busy = 1'b0;
      end else if (ack_cnt > 0) begin
         ack_cnt--;
         if (ack_cnt == 0) tx_busy = 1'b1;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic settle();
      @(negedge clock);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         settle();
      end
   endtask

   function automatic logic pick(input int which);
      case (which)
         0:       return fifo_read;
         1:       return tx_start;
         default: return tx_busy;
      endcase
   endfunction

   task automatic wait_for(input string name, input int which, input logic val, input int limit);
      bit hit = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (pick(which) === val) begin
            hit = 1'b1;
            break;
         end
         tick();
         settle();
      end
      chk(name, 32'(hit), 32'd1);
   endtask

   task automatic push_bytes(input logic [7:0] a, input logic [7:0] b);
      tick(); cpu_write = 1'b1; cpu_data = a; settle();
      tick(); cpu_data = b; settle();
      tick(); cpu_write = 1'b0; settle();
   endtask

   typedef struct {
      logic [4:0] stim;   // enable, cpu_write, fifo_full, flush, clear_overflow
      logic [7:0] data;
      logic [4:0] exp;    // fifo_write, cpu_ready, fifo_clear, fifo_read, overflow
   } vec_t;

   vec_t tbl[11];

   logic        m_busy, m_acked, m_ovf, e_idle, e_clear, e_read, e_start;
   logic [7:0]  m_byte;
   logic [15:0] m_cnt;
   int unsigned m_rd_cyc, m_ready;

   initial begin
      tbl[0]  = '{5'b11000, 8'h3C, 5'b11000};
      tbl[1]  = '{5'b10010, 8'h00, 5'b01100};
      tbl[2]  = '{5'b11010, 8'h55, 5'b01100};
      tbl[3]  = '{5'b11100, 8'h7E, 5'b00000};
      tbl[4]  = '{5'b10001, 8'h00, 5'b01001};
      tbl[5]  = '{5'b11101, 8'h81, 5'b00000};
      tbl[6]  = '{5'b10000, 8'h00, 5'b01001};
      tbl[7]  = '{5'b10001, 8'h00, 5'b01001};
      tbl[8]  = '{5'b10000, 8'h00, 5'b01000};
      tbl[9]  = '{5'b11000, 8'hC3, 5'b11000};
      tbl[10] = '{5'b10010, 8'h00, 5'b01100};

      reset = 1'b1; enable = 1'b0; cpu_write = 1'b0; cpu_data = 8'h00;
      flush = 1'b0; clear_overflow = 1'b0;
      idle_cycles(2);
      chk("rst_tx_start",   32'(tx_start),   32'd0);
      chk("rst_fifo_read",  32'(fifo_read),  32'd0);
      chk("rst_fifo_clear", 32'(fifo_clear), 32'd0);
      chk("rst_tx_data",    32'(tx_data),    32'd0);
      chk("rst_overflow",   32'(overflow),   32'd0);
      chk("rst_sent_count", 32'(sent_count), 32'd0);
      tick(); reset = 1'b0; settle();

      for (int i = 0; i < 11; i++) begin
         tick();
         {enable, cpu_write, force_full, flush, clear_overflow} = tbl[i].stim;
         cpu_data = tbl[i].data;
         settle();
         chk($sformatf("tbl%0d_fifo_write", i), 32'(fifo_write), 32'(tbl[i].exp[4]));
         chk($sformatf("tbl%0d_cpu_ready", i),  32'(cpu_ready),  32'(tbl[i].exp[3]));
         chk($sformatf("tbl%0d_fifo_clear", i), 32'(fifo_clear), 32'(tbl[i].exp[2]));
         chk($sformatf("tbl%0d_fifo_read", i),  32'(fifo_read),  32'(tbl[i].exp[1]));
         chk($sformatf("tbl%0d_overflow", i),   32'(overflow),   32'(tbl[i].exp[0]));
         chk($sformatf("tbl%0d_fifo_wdata", i), 32'(fifo_wdata), 32'(tbl[i].data));
      end
      tick();
      {enable, cpu_write, force_full, flush, clear_overflow} = 5'b00000;
      settle();
      chk("tbl_end_queue_empty", 32'(q_count), 32'd0);

      // Single byte timing, then second byte spaced by the gap.
      push_bytes(8'hA5, 8'h22);
      tick(); enable = 1'b1; ack_delay = 1; busy_len = 10; settle();
      wait_for("a_read", 0, 1'b1, 6);
      tick(); settle();
      chk("a_pop_read",  32'(fifo_read), 32'd0);
      chk("a_pop_start", 32'(tx_start),  32'd0);
      tick(); settle();
      chk("a_start", 32'(tx_start), 32'd1);
      chk("a_data",  32'(tx_data),  32'hA5);
      tick(); settle();
      chk("a_count",     32'(sent_count), 32'd1);
      chk("a_start_len", 32'(tx_start),   32'd0);
      wait_for("a_busy_hi", 2, 1'b1, 5);
      wait_for("a_busy_lo", 2, 1'b0, 15);
      for (int k = 0; k < 3; k++) begin
         tick(); settle();
         chk($sformatf("a_gap%0d_read", k), 32'(fifo_read), 32'd0);
      end
      tick(); settle();
      chk("a_gap_read", 32'(fifo_read), 32'd1);
      idle_cycles(2);
      chk("a2_start", 32'(tx_start), 32'd1);
      chk("a2_data",  32'(tx_data),  32'h22);
      tick(); enable = 1'b0; settle();
      chk("a2_count", 32'(sent_count), 32'd2);
      wait_for("a2_busy_hi", 2, 1'b1, 5);
      wait_for("a2_busy_lo", 2, 1'b0, 15);
      idle_cycles(6);

      // Flush outside IDLE is dropped; enable low stops new pops only.
      push_bytes(8'h5A, 8'h66);
      tick(); enable = 1'b1; ack_delay = 2; busy_len = 6; settle();
      wait_for("b_read", 0, 1'b1, 6);
      tick(); enable = 1'b0; settle();
      wait_for("b_start", 1, 1'b1, 4);
      chk("b_data", 32'(tx_data), 32'h5A);
      wait_for("b_busy_hi", 2, 1'b1, 6);
      tick(); flush = 1'b1; settle();
      chk("b_flush_busy_clear", 32'(fifo_clear), 32'd0);
      chk("b_flush_busy_read",  32'(fifo_read),  32'd0);
      tick(); flush = 1'b0; settle();
      wait_for("b_busy_lo", 2, 1'b0, 12);
      begin
         logic rd_seen = 1'b0;
         for (int k = 0; k < 10; k++) begin
            tick(); settle();
            rd_seen |= fifo_read;
         end
         chk("b_disabled_no_read", 32'(rd_seen), 32'd0);
      end
      chk("b_flush_not_queued", 32'(q_count), 32'd1);
      tick(); enable = 1'b1; flush = 1'b1; settle();
      chk("b_idle_flush_clear", 32'(fifo_clear), 32'd1);
      chk("b_idle_flush_read",  32'(fifo_read),  32'd0);
      tick(); enable = 1'b0; flush = 1'b0; settle();
      chk("b_clear_len",   32'(fifo_clear), 32'd0);
      chk("b_queue_empty", 32'(q_count),    32'd0);

      // Reset while in POP: byte lost, no start, FIFO contents kept.
      push_bytes(8'h99, 8'h31);
      tick(); enable = 1'b1; settle();
      wait_for("c_read", 0, 1'b1, 6);
      tick(); reset = 1'b1; settle();
      chk("c_pop_rst_start", 32'(tx_start), 32'd0);
      tick(); reset = 1'b0; enable = 1'b0; settle();
      chk("c_tx_start",   32'(tx_start),   32'd0);
      chk("c_fifo_read",  32'(fifo_read),  32'd0);
      chk("c_tx_data",    32'(tx_data),    32'd0);
      chk("c_sent_count", 32'(sent_count), 32'd0);
      chk("c_overflow",   32'(overflow),   32'd0);
      chk("c_fifo_kept",  32'(q_count),    32'd1);
      tick(); enable = 1'b1; settle();
      wait_for("c2_read", 0, 1'b1, 4);
      wait_for("c2_start", 1, 1'b1, 4);
      chk("c2_data", 32'(tx_data), 32'h31);
      tick(); enable = 1'b0; settle();
      chk("c2_count", 32'(sent_count), 32'd1);
      wait_for("c2_busy_hi", 2, 1'b1, 6);
      wait_for("c2_busy_lo", 2, 1'b0, 12);
      idle_cycles(6);

      // Byte counter wraps from 0xFFFF to 0x0000.
      force dut.sent_count = 16'hFFFF;
      tick(); settle();
      release dut.sent_count;
      push_bytes(8'h44, 8'h00);
      tick(); enable = 1'b1; settle();
      wait_for("d_read", 0, 1'b1, 4);
      tick(); enable = 1'b0; settle();
      wait_for("d_start", 1, 1'b1, 4);
      chk("d_data", 32'(tx_data), 32'h44);
      tick(); settle();
      chk("d_wrap", 32'(sent_count), 32'd0);
      wait_for("d_busy_hi", 2, 1'b1, 6);
      wait_for("d_busy_lo", 2, 1'b0, 12);
      idle_cycles(6);

      tick(); flush = 1'b1; settle();
      tick(); flush = 1'b0; reset = 1'b1; settle();
      tick(); settle();
      tick(); reset = 1'b0; settle();

      // Random traffic against a cycle-arithmetic model of the scheduler.
      m_busy = 1'b0; m_acked = 1'b0; m_ovf = 1'b0; m_cnt = 16'h0000;
      m_byte = 8'h00; m_rd_cyc = 0; m_ready = 0;
      for (int n = 0; n < 3000; n++) begin
         tick();
         enable         = ($urandom_range(0, 7) != 0);
         cpu_write      = ($urandom_range(0, 2) == 0);
         cpu_data       = 8'($urandom);
         flush          = ($urandom_range(0, 39) == 0);
         clear_overflow = ($urandom_range(0, 9) == 0);
         ack_delay      = int'($urandom_range(1, 3));
         busy_len       = int'($urandom_range(1, 6));
         settle();
         e_idle  = !m_busy && (cyc >= m_ready);
         e_clear = e_idle && flush;
         e_read  = e_idle && !flush && enable && !fifo_empty;
         e_start = m_busy && (cyc == m_rd_cyc + 2);
         chk("rnd_fifo_read",  32'(fifo_read),  32'(e_read));
         chk("rnd_fifo_clear", 32'(fifo_clear), 32'(e_clear));
         chk("rnd_tx_start",   32'(tx_start),   32'(e_start));
         chk("rnd_fifo_write", 32'(fifo_write), 32'(cpu_write && !fifo_full && !e_clear));
         chk("rnd_cpu_ready",  32'(cpu_ready),  32'(!fifo_full));
         chk("rnd_overflow",   32'(overflow),   32'(m_ovf));
         chk("rnd_sent_count", 32'(sent_count), 32'(m_cnt));
         if (e_start) chk("rnd_tx_data", 32'(tx_data), 32'(m_byte));
         if (e_read) begin
            m_busy   = 1'b1;
            m_acked  = 1'b0;
            m_rd_cyc = cyc;
            m_byte   = q[0];
         end else if (m_busy) begin
            if (m_acked && !tx_busy) begin
               m_busy  = 1'b0;
               m_ready = cyc + 1 + GAP;
            end else if (!m_acked && cyc >= m_rd_cyc + 3 && tx_busy) begin
               m_acked = 1'b1;
            end
         end
         if (e_start) m_cnt = m_cnt + 16'd1;
         m_ovf = (cpu_write && fifo_full) || (m_ovf && !clear_overflow);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
